count_extender: RTL and testbench

Downstream consumer of the 4-bit ripple counter. It samples the counter's `Q` bus and checks that every change is a legal +1 step (mod 16). It extends the count with a WRAP_W-bit wrap counter and hands out coherent {wrap, count} snapshots over a valid/ready handshake. It also flags illegal jumps with a sticky error bit.

---
 rtl/count_extender.sv | 115 +++++++++++
 tb/tb_count_extender.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_extender.sv
// count_extender: checks a 4-bit ripple counter's steps, extends it with a wrap
// counter and hands out coherent {wrap, count} snapshots over valid/ready.
module count_extender #(
  parameter int unsigned WRAP_W = 8
) (
  input  logic                clock,
  input  logic                reset_,
  input  logic                enable,
  input  logic [3:0]          q,
  input  logic                snap_req,
  input  logic                snap_ready,
  input  logic                err_clr,
  output logic                snap_valid,
  output logic [WRAP_W+3:0]   snap_data,
  output logic                wrap_pulse,
  output logic                err
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SNAP_W = WRAP_W + CNT_W;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    prev_q, prev_d;
  logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic                wrap_pulse_q, wrap_pulse_d;
  logic                err_q, err_d;
  logic                snap_valid_q, snap_valid_d;
  logic [SNAP_W-1:0]   snap_data_q, snap_data_d;
  logic [CNT_W-1:0]    prev_inc;

  assign prev_inc = CNT_W'(prev_q + CNT_W'(1));

  // Tracking FSM: first enabled sample is trusted, then every change must be +1 mod 16
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    wrap_cnt_d   = wrap_cnt_q;
    wrap_pulse_d = 1'b0;
    err_d        = err_q & ~err_clr;
    if (enable) begin
      unique case (state_q)
        ST_INIT: begin
          prev_d  = q;
          state_d = ST_TRACK;
        end
        ST_TRACK: begin
          if (q == prev_q) begin
            // counter paused; nothing to do
          end else if (q == prev_inc) begin
            prev_d = q;
            if (prev_q == 4'hF) begin
              wrap_cnt_d   = WRAP_W'(wrap_cnt_q + WRAP_W'(1));
              wrap_pulse_d = 1'b1;
            end
          end else begin
            // illegal jump: flag it and resynchronise to the observed value
            err_d  = 1'b1;
            prev_d = q;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // Snapshot handshake: capture post-edge values, hold until consumed, one idle cycle after
  always_comb begin
    snap_valid_d = snap_valid_q;
    snap_data_d  = snap_data_q;
    if (snap_valid_q) begin
      if (snap_ready) begin
        snap_valid_d = 1'b0;
      end
    end else if (snap_req) begin
      snap_valid_d = 1'b1;
      if (state_q == ST_INIT) begin
        snap_data_d = {wrap_cnt_q, q};
      end else begin
        snap_data_d = {wrap_cnt_d, prev_d};
      end
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q      <= ST_INIT;
      prev_q       <= '0;
      wrap_cnt_q   <= '0;
      wrap_pulse_q <= 1'b0;
      err_q        <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      wrap_cnt_q   <= wrap_cnt_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_q        <= err_d;
      snap_valid_q <= snap_valid_d;
      snap_data_q  <= snap_data_d;
    end
  end

  assign snap_valid = snap_valid_q;
  assign snap_data  = snap_data_q;
  assign wrap_pulse = wrap_pulse_q;
  assign err        = err_q;

endmodule

// File: tb/tb_count_extender.sv
// Bench for count_extender: step-check table plus directed snapshot, wrap and reset sequences.
module tb_count_extender;

  logic        clock;
  logic        reset_;
  logic        enable, snap_req, snap_ready, err_clr;
  logic [3:0]  q;
  logic        snap_valid, wrap_pulse, err;
  logic [11:0] snap_data;

  logic        enable2, snap_req2, snap_ready2, err_clr2;
  logic [3:0]  q2;
  logic        snap_valid2, wrap_pulse2, err2;
  logic [5:0]  snap_data2;

  int n_checks;
  int n_fail;
  int m_prev;
  int m_wrap;

  count_extender #(.WRAP_W(8)) dut (
    .clock(clock), .reset_(reset_), .enable(enable), .q(q),
    .snap_req(snap_req), .snap_ready(snap_ready), .err_clr(err_clr),
    .snap_valid(snap_valid), .snap_data(snap_data),
    .wrap_pulse(wrap_pulse), .err(err)
  );

  count_extender #(.WRAP_W(2)) dut2 (
    .clock(clock), .reset_(reset_), .enable(enable2), .q(q2),
    .snap_req(snap_req2), .snap_ready(snap_ready2), .err_clr(err_clr2),
    .snap_valid(snap_valid2), .snap_data(snap_data2),
    .wrap_pulse(wrap_pulse2), .err(err2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       en;
    logic [3:0] qv;
    logic       clr;
    logic       exp_pulse;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One legal +1 step on dut, tracked by the bench model
  task automatic step_legal();
    logic exp_p;
    exp_p  = (m_prev == 15);
    m_prev = (m_prev + 1) % 16;
    if (exp_p) m_wrap = (m_wrap + 1) % 256;
    q = 4'(m_prev);
    tick();
    chk("step_pulse", 32'(wrap_pulse), 32'(exp_p));
    chk("step_err", 32'(err), 32'd0);
  endtask

  initial begin
    int pulses;
    int v;
    n_checks = 0;
    n_fail   = 0;
    reset_ = 1'b0;
    enable = 1'b0; q = '0; snap_req = 1'b0; snap_ready = 1'b0; err_clr = 1'b0;
    enable2 = 1'b0; q2 = '0; snap_req2 = 1'b0; snap_ready2 = 1'b0; err_clr2 = 1'b0;
    #12;
    chk("rst_valid", 32'(snap_valid), 32'd0);
    chk("rst_data", 32'(snap_data), 32'd0);
    chk("rst_pulse", 32'(wrap_pulse), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset_ = 1'b1;

    // Full count with wrap, hold, illegal jump, clear, freeze, set-wins-over-clear
    vecs.push_back('{1'b1, 4'd0, 1'b0, 1'b0, 1'b0});
    for (int i = 1; i < 16; i++) vecs.push_back('{1'b1, 4'(i), 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd2, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd3, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd3, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd3, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd4, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd7, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'd7, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd8, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd2, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'd3, 1'b1, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      enable  = vecs[i].en;
      q       = vecs[i].qv;
      err_clr = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d_pulse", i), 32'(wrap_pulse), 32'(vecs[i].exp_pulse));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
    end
    err_clr = 1'b0;
    m_prev = 3;
    m_wrap = 1;

    // Snapshot at count 9, wrap 2; held while the count advances
    while (!(m_wrap == 2 && m_prev == 9)) step_legal();
    snap_req = 1'b1;
    tick();
    chk("snap_valid", 32'(snap_valid), 32'd1);
    chk("snap_029", 32'(snap_data), 32'h029);
    snap_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_legal();
      chk("snap_hold_valid", 32'(snap_valid), 32'd1);
      chk("snap_hold_data", 32'(snap_data), 32'h029);
    end
    snap_ready = 1'b1;
    snap_req   = 1'b1;
    tick();
    chk("snap_consumed", 32'(snap_valid), 32'd0);
    snap_ready = 1'b0;
    tick();
    chk("snap_reissue_valid", 32'(snap_valid), 32'd1);
    chk("snap_reissue_data", 32'(snap_data), 32'h02E);
    snap_req   = 1'b0;
    snap_ready = 1'b1;
    tick();
    chk("snap_reissue_done", 32'(snap_valid), 32'd0);
    snap_ready = 1'b0;

    // Snapshot on the same edge as a wrap includes the new wrap count
    while (!(m_wrap == 5 && m_prev == 15)) step_legal();
    snap_req = 1'b1;
    step_legal();
    chk("snap_wrap_valid", 32'(snap_valid), 32'd1);
    chk("snap_060", 32'(snap_data), 32'h060);
    snap_req   = 1'b0;
    snap_ready = 1'b1;
    tick();
    chk("snap_wrap_done", 32'(snap_valid), 32'd0);
    snap_ready = 1'b0;

    // Narrow wrap counter rolls over silently
    enable  = 1'b0;
    enable2 = 1'b1;
    q2      = 4'd0;
    tick();
    pulses = 0;
    for (int w = 1; w <= 4; w++) begin
      for (int k = 1; k <= 16; k++) begin
        v = k % 16;
        q2          = 4'(v);
        snap_req2   = (v == 0);
        snap_ready2 = (v == 1);
        tick();
        if (wrap_pulse2) pulses++;
        chk("w2_pulse", 32'(wrap_pulse2), 32'(v == 0));
        if (v == 0) begin
          chk("w2_snap", 32'(snap_data2), 32'(w % 4) << 4);
        end
      end
    end
    snap_req2 = 1'b0;
    snap_ready2 = 1'b1;
    tick();
    snap_ready2 = 1'b0;
    chk("w2_pulse_count", 32'(pulses), 32'd4);
    chk("w2_err", 32'(err2), 32'd0);
    enable2 = 1'b0;

    // Asynchronous reset with pending snapshot and sticky error
    enable = 1'b1;
    q = 4'd5;
    tick();
    chk("pre_rst_err", 32'(err), 32'd1);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("pre_rst_valid", 32'(snap_valid), 32'd1);
    #2 reset_ = 1'b0;
    #1;
    chk("arst_valid", 32'(snap_valid), 32'd0);
    chk("arst_data", 32'(snap_data), 32'd0);
    chk("arst_pulse", 32'(wrap_pulse), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    #2 reset_ = 1'b1;
    q = 4'd11;
    tick();
    chk("post_rst_init_err", 32'(err), 32'd0);
    q = 4'd12;
    tick();
    chk("post_rst_step_err", 32'(err), 32'd0);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("post_rst_snap", 32'(snap_data), 32'h00C);
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
    chk("post_rst_snap_done", 32'(snap_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
